// File: rtl/rf_port_arbiter.sv
// Shares the register file command port between the core pipeline and a debug
// requester: fixed core priority, starvation-forced debug slot, 2-cycle return.
module rf_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic [31:0] core_inst,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rs1data,
    output logic [31:0] core_rs2data,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_wdone,

    output logic [31:0] rf_inst,
    output logic        rf_regwr,
    output logic [31:0] rf_wrdata,
    input  logic [31:0] rf_rs1data,
    input  logic [31:0] rf_rs2data,
    input  logic        rf_wb_update,
    output logic        rf_err
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Tag travelling alongside each command so its return can be attributed.
    typedef struct packed {
        logic vld;
        logic dbg;
        logic wr;
    } tag_t;

    logic [CNT_W-1:0] starve_cnt;
    logic             force_dbg;
    tag_t             s1_tag;
    tag_t             s2_tag;
    logic             wr_tag;
    logic [31:0]      dbg_cmd;

    // Handshake: a requester raises req with stable fields; the command is taken
    // in the cycle gnt is high. Without gnt the requester holds everything.
    always_comb begin
        force_dbg = dbg_req && (starve_cnt >= LIMIT);
        dbg_gnt   = dbg_req && (!core_req || force_dbg);
        core_gnt  = core_req && !dbg_gnt;
        dbg_cmd   = {12'b0, dbg_addr, 3'b0, dbg_addr, 7'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_inst   <= '0;
            rf_regwr  <= 1'b0;
            rf_wrdata <= '0;
            s1_tag    <= '0;
        end else begin
            rf_regwr <= 1'b0;
            s1_tag   <= '0;
            if (core_gnt) begin
                rf_inst   <= core_inst;
                rf_regwr  <= core_we;
                rf_wrdata <= core_wdata;
                s1_tag    <= '{vld: 1'b1, dbg: 1'b0, wr: core_we};
            end else if (dbg_gnt) begin
                rf_inst   <= dbg_cmd;
                rf_regwr  <= dbg_we;
                rf_wrdata <= dbg_wdata;
                s1_tag    <= '{vld: 1'b1, dbg: 1'b1, wr: dbg_we};
            end
        end
    end

    // Second stage lines up with the register file's registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_tag <= '0;
        end else begin
            s2_tag <= s1_tag;
        end
    end

    assign wr_tag       = s2_tag.vld && s2_tag.wr;
    assign core_rvalid  = s2_tag.vld && !s2_tag.dbg;
    assign dbg_rvalid   = s2_tag.vld && s2_tag.dbg && !s2_tag.wr;
    assign dbg_wdone    = wr_tag && s2_tag.dbg && rf_wb_update;
    assign core_rs1data = rf_rs1data;
    assign core_rs2data = rf_rs2data;
    assign dbg_rdata    = rf_rs1data;

    // Acknowledge must match the write tag exactly; any disagreement is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_err <= 1'b0;
        end else if (wr_tag != rf_wb_update) begin
            rf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: register file environment, directed scenarios with
// literal expectations, and a randomized phase checked against a behavioural model.
module tb_rf_port_arbiter;

    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0;
    logic [31:0] core_inst = '0;
    logic        core_we = 1'b0;
    logic [31:0] core_wdata = '0;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rs1data, core_rs2data;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid, dbg_wdone;
    logic [31:0] dbg_rdata;
    logic [31:0] rf_inst, rf_wrdata;
    logic        rf_regwr, rf_err;
    logic [31:0] rf_rs1data, rf_rs2data;
    logic        rf_wb_update;

    rf_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_inst(core_inst), .core_we(core_we),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rs1data(core_rs1data), .core_rs2data(core_rs2data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_wdone(dbg_wdone),
        .rf_inst(rf_inst), .rf_regwr(rf_regwr), .rf_wrdata(rf_wrdata),
        .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data),
        .rf_wb_update(rf_wb_update), .rf_err(rf_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- register file environment ----------------
    logic [31:0] rf_mem [32] = '{default: '0};
    logic [31:0] rs1_q = '0;
    logic [31:0] rs2_q = '0;
    logic        wb_raw = 1'b0;
    logic        kill_ack = 1'b0;
    logic        spurious = 1'b0;

    always @(posedge clk) begin
        rs1_q  <= (rf_inst[19:15] == 5'd0) ? 32'd0 : rf_mem[rf_inst[19:15]];
        rs2_q  <= (rf_inst[24:20] == 5'd0) ? 32'd0 : rf_mem[rf_inst[24:20]];
        wb_raw <= rf_regwr;
        if (rf_regwr && rf_inst[11:7] != 5'd0) rf_mem[rf_inst[11:7]] <= rf_wrdata;
    end

    assign rf_rs1data   = rs1_q;
    assign rf_rs2data   = rs2_q;
    assign rf_wb_update = (wb_raw & ~kill_ack) | spurious;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    typedef struct packed {
        logic [31:0] due;
        logic        dbg;
        logic        we;
        logic [31:0] d1;
        logic [31:0] d2;
    } ret_t;

    ret_t        exp_q[$];
    ret_t        e;
    logic [31:0] m_regs [32] = '{default: '0};
    logic        pend_v = 1'b0;
    logic [4:0]  pend_rd = '0;
    logic [31:0] pend_wd = '0;
    logic [31:0] m_inst = '0;
    logic        m_regwr = 1'b0;
    logic [31:0] m_wdata = '0;
    int          m_denied = 0;
    logic        m_err = 1'b0;
    logic        m_cg, m_dg, have;
    logic        last_core_gnt = 1'b0;
    logic        last_dbg_gnt = 1'b0;
    logic [31:0] cyc = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                pend_v = 1'b0;
                m_inst = '0; m_regwr = 1'b0; m_wdata = '0;
                m_denied = 0; m_err = 1'b0;
                last_core_gnt = 1'b0; last_dbg_gnt = 1'b0;
            end else begin
                cyc++;
                // Debug wins when the core is idle or after STARVE_LIMIT straight denials.
                m_dg = dbg_req && (!core_req || m_denied >= STARVE_LIMIT);
                m_cg = core_req && !m_dg;
                chk("dbg_gnt", 32'(dbg_gnt), 32'(m_dg));
                chk("core_gnt", 32'(core_gnt), 32'(m_cg));
                chk("rf_inst", rf_inst, m_inst);
                chk("rf_regwr", 32'(rf_regwr), 32'(m_regwr));
                if (m_regwr) chk("rf_wrdata", rf_wrdata, m_wdata);

                have = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                e = '0;
                if (have) e = exp_q.pop_front();
                chk("core_rvalid", 32'(core_rvalid), 32'(have && !e.dbg));
                chk("dbg_rvalid", 32'(dbg_rvalid), 32'(have && e.dbg && !e.we));
                chk("dbg_wdone", 32'(dbg_wdone), 32'(have && e.dbg && e.we && rf_wb_update));
                if (have && !e.dbg) begin
                    chk("core_rs1data", core_rs1data, e.d1);
                    chk("core_rs2data", core_rs2data, e.d2);
                end
                if (have && e.dbg && !e.we) chk("dbg_rdata", dbg_rdata, e.d1);
                chk("rf_err", 32'(rf_err), 32'(m_err));
                if ((have && e.we) != rf_wb_update) m_err = 1'b1;

                // Earlier grant's write lands before this grant's read.
                if (pend_v && pend_rd != 5'd0) m_regs[pend_rd] = pend_wd;
                pend_v  = 1'b0;
                m_regwr = 1'b0;
                if (m_cg) begin
                    exp_q.push_back('{due: cyc + 2, dbg: 1'b0, we: core_we,
                                      d1: m_regs[core_inst[19:15]], d2: m_regs[core_inst[24:20]]});
                    pend_v = core_we; pend_rd = core_inst[11:7]; pend_wd = core_wdata;
                    m_inst = core_inst; m_regwr = core_we; m_wdata = core_wdata;
                end else if (m_dg) begin
                    exp_q.push_back('{due: cyc + 2, dbg: 1'b1, we: dbg_we,
                                      d1: m_regs[dbg_addr], d2: 32'd0});
                    pend_v = dbg_we; pend_rd = dbg_addr; pend_wd = dbg_wdata;
                    m_inst = {12'b0, dbg_addr, 3'b0, dbg_addr, 7'b0};
                    m_regwr = dbg_we; m_wdata = dbg_wdata;
                end
                m_denied = (dbg_req && !m_dg) ? m_denied + 1 : 0;
                last_core_gnt = m_cg;
                last_dbg_gnt  = m_dg;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            core_req = 1'b0;
            dbg_req  = 1'b0;
        end
    endtask

    task automatic dbg_issue(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        core_req = 1'b0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic core_issue(input logic [31:0] inst, input logic we, input logic [31:0] d);
        @(posedge clk); #1;
        dbg_req = 1'b0;
        core_req = 1'b1; core_inst = inst; core_we = we; core_wdata = d;
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (!core_req || last_core_gnt) begin
                core_req   = ($urandom_range(0, 99) < 60);
                core_inst  = $urandom;
                core_we    = 1'($urandom_range(0, 1));
                core_wdata = $urandom;
            end
            if (!dbg_req || last_dbg_gnt) begin
                dbg_req   = ($urandom_range(0, 99) < 50);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 5'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
        end
        idle(4);
    endtask

    // ---------------- directed + random sequence ----------------
    int first_dbg, second_dbg;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Reset with a debug write in flight: that write must vanish.
        dbg_issue(1'b1, 5'd7, 32'h11111111);
        dbg_issue(1'b1, 5'd7, 32'h22222222);
        @(posedge clk); #1;
        rst = 1'b0; dbg_req = 1'b0;
        #1;
        chk("rst_rf_inst", rf_inst, 32'd0);
        chk("rst_rf_regwr", 32'(rf_regwr), 32'd0);
        chk("rst_rf_wrdata", rf_wrdata, 32'd0);
        chk("rst_rf_err", 32'(rf_err), 32'd0);
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_dbg_wdone", 32'(dbg_wdone), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_wdone", 32'(dbg_wdone), 32'd0);
            chk("post_rst_rvalid", 32'(core_rvalid), 32'd0);
            chk("post_rst_err", 32'(rf_err), 32'd0);
        end
        dbg_issue(1'b0, 5'd7, 32'd0);
        idle(2);
        @(negedge clk);
        chk("x7_after_rst_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("x7_after_rst_data", dbg_rdata, 32'h11111111);

        // Debug write x5 then read it back the next cycle.
        dbg_issue(1'b1, 5'd5, 32'hDEADBEEF);
        dbg_issue(1'b0, 5'd5, 32'd0);
        idle(1);
        @(negedge clk);
        chk("x5_wdone", 32'(dbg_wdone), 32'd1);
        chk("x5_read_cmd", rf_inst, 32'h00028280);
        idle(1);
        @(negedge clk);
        chk("x5_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("x5_rdata", dbg_rdata, 32'hDEADBEEF);

        // Debug write to x0 is acknowledged but reads still return 0.
        dbg_issue(1'b1, 5'd0, 32'h00001234);
        dbg_issue(1'b0, 5'd0, 32'd0);
        idle(1);
        @(negedge clk);
        chk("x0_wdone", 32'(dbg_wdone), 32'd1);
        idle(1);
        @(negedge clk);
        chk("x0_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("x0_rdata", dbg_rdata, 32'd0);

        // Core read latency: add x0,x1,x2 with x1=3, x2=4.
        dbg_issue(1'b1, 5'd1, 32'd3);
        dbg_issue(1'b1, 5'd2, 32'd4);
        core_issue(32'h00208033, 1'b1, 32'h55);
        idle(1);
        @(negedge clk);
        chk("add_regwr", 32'(rf_regwr), 32'd1);
        chk("add_early_rvalid", 32'(core_rvalid), 32'd0);
        idle(1);
        @(negedge clk);
        chk("add_rvalid", 32'(core_rvalid), 32'd1);
        chk("add_rs1", core_rs1data, 32'd3);
        chk("add_rs2", core_rs2data, 32'd4);

        // Both requesters held: debug is forced in on the 9th cycle, then again 9 later.
        idle(1);
        @(posedge clk); #1;
        core_req = 1'b1; core_inst = 32'h00308133; core_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        first_dbg = -1; second_dbg = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg_gnt) begin
                if (first_dbg < 0) first_dbg = i;
                else if (second_dbg < 0) second_dbg = i;
            end
            if (i == 9) chk("core_resumes", 32'(core_gnt), 32'd1);
        end
        chk("first_dbg_slot", 32'(first_dbg), 32'd8);
        chk("second_dbg_slot", 32'(second_dbg), 32'd17);
        idle(3);

        run_random(600);

        // Missing acknowledge on a debug write return.
        dbg_issue(1'b1, 5'd9, 32'h0000A5A5);
        idle(1);
        @(posedge clk); #1 kill_ack = 1'b1;
        @(negedge clk);
        chk("noack_wdone", 32'(dbg_wdone), 32'd0);
        @(posedge clk); #1 kill_ack = 1'b0;
        @(negedge clk);
        chk("noack_err", 32'(rf_err), 32'd1);
        idle(3);
        @(negedge clk);
        chk("err_sticky", 32'(rf_err), 32'd1);

        // Spurious acknowledge with nothing in flight.
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(rf_err), 32'd0);
        @(posedge clk); #1 spurious = 1'b1;
        @(posedge clk); #1 spurious = 1'b0;
        @(negedge clk);
        chk("spurious_err", 32'(rf_err), 32'd1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the RV32I register file's single command port between the core pipeline and a debug requester. The register file has a 32-bit instruction-format command (rs1 at [19:15], rs2 at [24:20], rd at [11:7]), a write enable, write data, registered read data and a wb_update flag.
- The core has fixed priority over debug. A starvation counter forces a debug slot after a bounded wait.
- Commands are issued registered, and read data is returned with valid strobes.
- Write completion is checked against the register file's wb_update.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles debug may be denied before it is forced to win.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core requests a register-file command this cycle.
- core_inst  in  32  core instruction word; rs1/rs2/rd fields are used as-is.
- core_we  in  1  core command writes rd.
- core_wdata  in  32  core write data.
- core_gnt  out  1  combinational; core command accepted this cycle.
- core_rvalid  out  1  core rs1/rs2 data valid.
- core_rs1data  out  32  rs1 read data for the core.
- core_rs2data  out  32  rs2 read data for the core.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write (1) or read (0).
- dbg_addr  in  5  debug register index.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  combinational; debug command accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  32  debug read data.
- dbg_wdone  out  1  debug write committed.
- rf_inst  out  32  registered command word to the register file.
- rf_regwr  out  1  registered write enable to the register file.
- rf_wrdata  out  32  registered write data to the register file.
- rf_rs1data  in  32  register file rs1 output.
- rf_rs2data  in  32  register file rs2 output.
- rf_wb_update  in  1  register file write-acknowledge.
- rf_err  out  1  sticky error flag: write acknowledge missing or unexpected.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs go to 0: rf_inst, rf_regwr, rf_wrdata, rf_err, the valid/done strobes and the starvation counter.
  - All in-flight pipeline tags are cleared. In-flight transactions are dropped and produce no rvalid or wdone after reset deasserts.
- Arbitration (cycle N, combinational):
  - force = (starve_cnt >= STARVE_LIMIT) && dbg_req.
  - dbg_gnt = dbg_req && (!core_req || force).
  - core_gnt = core_req && !dbg_gnt.
  - At most one grant per cycle. Back-to-back grants every cycle are allowed.
- Starvation counter:
  - Increments, saturating at 2^CNT_W-1, in each cycle with dbg_req && !dbg_gnt.
  - Clears to 0 on dbg_gnt or when dbg_req=0.
- Issue (edge ending N):
  - Core grant: rf_inst<=core_inst, rf_regwr<=core_we, rf_wrdata<=core_wdata.
  - Debug grant: rf_inst<={12'b0, dbg_addr, 3'b0, dbg_addr, 7'b0} (rs1=rd=dbg_addr, rs2=0), rf_regwr<=dbg_we, rf_wrdata<=dbg_wdata.
  - No grant: rf_regwr<=0 and rf_inst holds its previous value.
  - The stage-1 tag {owner, is_write} is registered alongside the command.
- Register file (cycle N+1): writes and registers read data at the edge ending N+1.
- Return (cycle N+2):
  - core_rvalid=1 for every core grant.
  - dbg_rvalid=1 for debug reads only.
  - core_rs1data/core_rs2data/dbg_rdata pass through rf_rs1data/rf_rs2data combinationally. Values are don't-care when the matching valid is 0.
  - Latency is a fixed 2 cycles from grant to valid.
- Write check (cycle N+2):
  - For any write tag, rf_wb_update must be 1; otherwise rf_err<=1.
  - rf_wb_update=1 with no write tag also sets rf_err.
  - dbg_wdone=1 for a debug write tag with rf_wb_update=1.
  - rf_err clears only on reset.
- Hazards:
  - A command whose rs1 or rs2 equals its own rd returns the pre-write value.
  - A read granted the cycle after a write to the same register returns the new value; no bypass is needed.
  - A write to x0 is acknowledged (wdone=1) but has no effect, and reads of x0 return 0.
- Requester obligations:
  - A requester without a grant must hold its request and fields stable.
  - The arbiter does not queue commands.

Test Plan:
- Reset values: rst low mid-stream with a write in flight -> all outputs 0 immediately. After release, no dbg_wdone/core_rvalid for the dropped command, and rf_err=0.
- Debug write then read: dbg write x5=0xDEADBEEF at N, read x5 at N+1 -> dbg_wdone at N+2, dbg_rvalid at N+3 with dbg_rdata=0xDEADBEEF. rf_inst for the read = 0x00028280.
- Core priority: core_req and dbg_req both held continuously, STARVE_LIMIT=8 -> core_gnt for 8 cycles, dbg_gnt on the 9th cycle only, then core resumes and the counter is back to 0.
- Core read latency: core_inst=0x00208033 (add x0,x1,x2) with x1=3, x2=4 -> core_rvalid exactly 2 cycles after core_gnt with rs1data=3, rs2data=4. rf_regwr follows core_we.
- Error detect: force rf_wb_update=0 during a debug-write return cycle -> rf_err=1 and sticky, dbg_wdone=0. A spurious rf_wb_update with no write tag also sets it.
- Debug write to x0: value 0x1234 -> dbg_wdone=1. A subsequent read returns 0.
